// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch front end
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam int INST_BYTES = 4;

    // Clears the byte-offset bits of an address; sliced to the address width by users.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with flush taking priority over push and pop
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, do_push, do_pop;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign o_empty = count_q == '0;
    assign do_push = i_push && !full;
    assign do_pop  = i_pop && !o_empty;
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates visibility
    always_ff @(posedge i_clk) begin
        if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: registered-PC fetch front end with one outstanding memory request and a prefetch buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_imem_req,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_inst_valid,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    output logic [ADDR_WIDTH-1:0] o_inst_pc4,
    input  logic                  i_inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN = WORD_ALIGN_MASK[ADDR_WIDTH-1:0];

    state_e                           state_q;
    logic [ADDR_WIDTH-1:0]            fetch_pc_q, issued_pc_q;
    logic [CW-1:0]                    fifo_count;
    logic                             fifo_empty, push, pop;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0]            head_pc;

    assign head_pc      = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign o_imem_req   = !i_rst && state_q == S_REQ && fifo_count < CW'(FIFO_DEPTH) && !i_redirect;
    assign o_imem_addr  = i_rst ? '0 : fetch_pc_q;
    assign push         = state_q == S_WAIT && i_imem_rvalid && !i_redirect;
    assign o_inst_valid = !i_rst && !fifo_empty;
    assign pop          = o_inst_valid && i_inst_ready;
    assign o_inst       = o_inst_valid ? head[DATA_WIDTH-1:0] : '0;
    assign o_inst_pc    = o_inst_valid ? head_pc : '0;
    assign o_inst_pc4   = o_inst_valid ? head_pc + ADDR_WIDTH'(INST_BYTES) : '0;

    fetch_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_flush(i_redirect),
        .i_push (push),
        .i_data ({issued_pc_q, i_imem_rdata}),
        .i_pop  (pop),
        .o_head (head),
        .o_count(fifo_count),
        .o_empty(fifo_empty)
    );

    // Fetch FSM: redirect retargets the PC and turns any outstanding request into one to discard
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
        end else if (i_redirect) begin
            fetch_pc_q <= i_redirect_pc & ALIGN;
            state_q    <= (state_q != S_REQ && !i_imem_rvalid) ? S_DROP : S_REQ;
        end else begin
            case (state_q)
                S_REQ: if (o_imem_req && i_imem_gnt) begin
                    issued_pc_q <= fetch_pc_q;
                    fetch_pc_q  <= fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
                    state_q     <= S_WAIT;
                end
                S_WAIT:  if (i_imem_rvalid) state_q <= S_REQ;
                S_DROP:  if (i_imem_rvalid) state_q <= S_REQ;
                default: state_q <= S_REQ;
            endcase
        end
    end

    // A response with nothing outstanding breaks the memory protocol
    a_no_rvalid_idle: assert property (@(posedge i_clk) disable iff (i_rst)
        !(state_q == S_REQ && i_imem_rvalid));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle vectors for the fetch front end
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, req, gnt, rvalid, redirect, valid, ready;
    logic [31:0] addr, rdata, redirect_pc, inst, pc, pc4;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0040_0000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_inst_valid (valid),
        .o_inst       (inst),
        .o_inst_pc    (pc),
        .o_inst_pc4   (pc4),
        .i_inst_ready (ready)
    );

    typedef struct {
        logic        rst, gnt, rv;
        logic [31:0] rdata;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst, e_pc;
    } vec_t;

    localparam logic [31:0] I0 = 32'h0000_1013, I1 = 32'h0000_2093, I2 = 32'h0000_3113;
    localparam logic [31:0] I3 = 32'h0000_4193, I4 = 32'h0000_5213, I5 = 32'h0000_6293;
    localparam logic [31:0] I6 = 32'h0000_7313, I7 = 32'h0000_8393, I8 = 32'h0000_9413;
    localparam logic [31:0] I9 = 32'h0000_A493, I10 = 32'h0000_B513;

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rdat, logic rd, logic [31:0] rpc,
                                logic rdy, logic e_req, logic [31:0] e_addr, logic e_val,
                                logic [31:0] e_inst, logic [31:0] e_pc);
        vec_t v;
        v.rst = 1'b0; v.gnt = g; v.rv = rv; v.rdata = rdat; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    // Drive one cycle of inputs away from the clock edge, then compare every output
    task automatic apply(input vec_t v, input string tag, input int id);
        logic [31:0]  e_pc4;
        logic [129:0] got, exp;
        @(negedge clk);
        rst = v.rst; gnt = v.gnt; rvalid = v.rv; rdata = v.rdata;
        redirect = v.rd; redirect_pc = v.rpc; ready = v.rdy;
        #1;
        e_pc4 = v.e_val ? v.e_pc + 32'd4 : 32'd0;
        got = {req, addr, valid, inst, pc, pc4};
        exp = {v.e_req, v.e_addr, v.e_val, v.e_inst, v.e_pc, e_pc4};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got req=%b addr=%h valid=%b inst=%h pc=%h pc4=%h, expected req=%b addr=%h valid=%b inst=%h pc=%h pc4=%h",
                     tag, id, req, addr, valid, inst, pc, pc4,
                     v.e_req, v.e_addr, v.e_val, v.e_inst, v.e_pc, e_pc4);
        end
    endtask

    initial begin
        vec_t q[$];
        vec_t r;
        int   n;
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r = mk(0,0,0, 0,0, 0, 0,32'h0,0,0,0);
        r.rst = 1'b1;
        q.push_back(r);
        //        gnt rv rdata          rd rpc            rdy  req addr           val inst           pc
        q.push_back(mk(1,0,0,            0,0,            1,   1,32'h0040_0000,0,0,            0));
        q.push_back(mk(1,1,32'h2008_0005,0,0,            1,   0,32'h0040_0004,0,0,            0));
        q.push_back(mk(0,0,0,            0,0,            0,   1,32'h0040_0004,1,32'h2008_0005,32'h0040_0000));
        q.push_back(mk(0,0,0,            0,0,            1,   1,32'h0040_0004,1,32'h2008_0005,32'h0040_0000));
        q.push_back(mk(1,0,0,            1,32'h0,        0,   0,32'h0040_0004,0,0,            0));
        q.push_back(mk(1,0,0,            0,0,            0,   1,32'h0,        0,0,            0));
        q.push_back(mk(0,1,I0,           0,0,            0,   0,32'h4,        0,0,            0));
        q.push_back(mk(1,0,0,            0,0,            0,   1,32'h4,        1,I0,           32'h0));
        q.push_back(mk(0,1,I1,           0,0,            0,   0,32'h8,        1,I0,           32'h0));
        q.push_back(mk(1,0,0,            0,0,            0,   1,32'h8,        1,I0,           32'h0));
        q.push_back(mk(0,1,I2,           0,0,            0,   0,32'hC,        1,I0,           32'h0));
        q.push_back(mk(1,0,0,            0,0,            0,   1,32'hC,        1,I0,           32'h0));
        q.push_back(mk(0,1,I3,           0,0,            0,   0,32'h10,       1,I0,           32'h0));
        q.push_back(mk(1,0,0,            0,0,            0,   0,32'h10,       1,I0,           32'h0));
        q.push_back(mk(1,0,0,            0,0,            0,   0,32'h10,       1,I0,           32'h0));
        q.push_back(mk(1,0,0,            0,0,            1,   0,32'h10,       1,I0,           32'h0));
        q.push_back(mk(1,0,0,            0,0,            1,   1,32'h10,       1,I1,           32'h4));
        q.push_back(mk(0,0,0,            0,0,            1,   0,32'h14,       1,I2,           32'h8));
        q.push_back(mk(0,1,I4,           0,0,            1,   0,32'h14,       1,I3,           32'hC));
        q.push_back(mk(0,0,0,            0,0,            0,   1,32'h14,       1,I4,           32'h10));
        q.push_back(mk(1,0,0,            1,32'h103,      1,   0,32'h14,       1,I4,           32'h10));
        q.push_back(mk(1,0,0,            0,0,            0,   1,32'h100,      0,0,            0));
        q.push_back(mk(0,1,I5,           0,0,            0,   0,32'h104,      0,0,            0));
        q.push_back(mk(0,0,0,            0,0,            1,   1,32'h104,      1,I5,           32'h100));
        q.push_back(mk(0,0,0,            1,32'hFFFF_FFFC,0,   0,32'h104,      0,0,            0));
        q.push_back(mk(1,0,0,            0,0,            0,   1,32'hFFFF_FFFC,0,0,            0));
        q.push_back(mk(0,1,I6,           0,0,            0,   0,32'h0,        0,0,            0));
        q.push_back(mk(0,0,0,            0,0,            0,   1,32'h0,        1,I6,           32'hFFFF_FFFC));
        q.push_back(mk(0,0,0,            0,0,            1,   1,32'h0,        1,I6,           32'hFFFF_FFFC));
        q.push_back(mk(0,0,0,            0,0,            0,   1,32'h0,        0,0,            0));
        n = q.size();
        for (int i = 0; i < n; i++) apply(q[i], "vec", i);

        // Redirect while a request is outstanding; the late response must be discarded
        apply(mk(1,0,0,            0,0,       0, 1,32'h0,  0,0,0), "drop", 0);
        apply(mk(0,0,0,            1,32'h100, 0, 0,32'h4,  0,0,0), "drop", 1);
        apply(mk(0,0,0,            0,0,       0, 0,32'h100,0,0,0), "drop", 2);
        apply(mk(0,1,32'hDEAD_BEEF,0,0,       0, 0,32'h100,0,0,0), "drop", 3);
        apply(mk(0,0,0,            0,0,       1, 1,32'h100,0,0,0), "drop", 4);
        apply(mk(0,0,0,            0,0,       1, 1,32'h100,0,0,0), "drop", 5);

        // Redirect, pop and response land together with two entries buffered
        apply(mk(1,0,0, 0,0,       0, 1,32'h100,0,0,  0),       "same", 0);
        apply(mk(0,1,I7,0,0,       0, 0,32'h104,0,0,  0),       "same", 1);
        apply(mk(1,0,0, 0,0,       0, 1,32'h104,1,I7, 32'h100), "same", 2);
        apply(mk(0,1,I8,0,0,       0, 0,32'h108,1,I7, 32'h100), "same", 3);
        apply(mk(1,0,0, 0,0,       0, 1,32'h108,1,I7, 32'h100), "same", 4);
        apply(mk(0,1,I9,1,32'h200, 1, 0,32'h10C,1,I7, 32'h100), "same", 5);
        apply(mk(0,0,0, 0,0,       1, 1,32'h200,0,0,  0),       "same", 6);
        apply(mk(1,0,0, 0,0,       0, 1,32'h200,0,0,  0),       "same", 7);
        apply(mk(0,1,I10,0,0,      0, 0,32'h204,0,0,  0),       "same", 8);
        apply(mk(0,0,0, 0,0,       0, 1,32'h204,1,I10,32'h200), "same", 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
